// File: rtl/nx_indirect_access_initiator_pkg.sv
// Shared encodings for the indirect-access initiator: FSM states, opcodes,
// status codes and register field positions.
package nx_ia_initiator_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_WR_DATA   = 4'd1,
    ST_WR_CMND   = 4'd2,
    ST_POLL_RD   = 4'd3,
    ST_POLL_WAIT = 4'd4,
    ST_GAP       = 4'd5,
    ST_DATA_RD   = 4'd6,
    ST_DATA_WAIT = 4'd7,
    ST_RESP      = 4'd8
  } ia_state_e;

  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;

  // Must stay aligned with the codes driven by nx_indirect_access_cntrl.
  localparam logic [2:0] STAT_OK   = 3'd0;
  localparam logic [2:0] STAT_BUSY = 3'd1;
  localparam logic [2:0] STAT_WDOG = 3'd7;

  localparam int CMD_OP_LSB    = 28;
  localparam int STAT_CODE_LSB = 29;
  localparam int GAP_W         = 4;

  function automatic logic [2:0] stat_code(input logic [31:0] word);
    return word[STAT_CODE_LSB +: 3];
  endfunction

endpackage

// File: rtl/nx_indirect_access_initiator_wait_timer.sv
// Poll counter, inter-poll gap counter and ack watchdog used by the
// indirect-access initiator FSM.
module nx_ia_wait_timer
  import nx_ia_initiator_pkg::*;
#(
  parameter int N_TIMEOUT_BITS = 8,
  parameter int POLL_GAP       = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic poll_clr,
  input  logic poll_inc,
  input  logic gap_load,
  input  logic wd_clr,
  input  logic wd_run,
  output logic poll_at_max,
  output logic gap_done,
  output logic wd_expired
);

  localparam logic [N_TIMEOUT_BITS-1:0] ALL_ONES = '1;
  localparam logic [N_TIMEOUT_BITS-1:0] WD_START = N_TIMEOUT_BITS'(1);
  localparam logic [GAP_W-1:0] GAP_RELOAD =
    (POLL_GAP == 0) ? '0 : GAP_W'(POLL_GAP - 1);

  logic [N_TIMEOUT_BITS-1:0] poll_cnt;
  logic [N_TIMEOUT_BITS-1:0] wd_cnt;
  logic [GAP_W-1:0]          gap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt <= '0;
    end else if (poll_clr) begin
      poll_cnt <= '0;
    end else if (poll_inc) begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (gap_load) begin
      gap_cnt <= GAP_RELOAD;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // The watchdog restarts at 1 so the count equals the number of wait
  // cycles seen so far; it saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (wd_clr) begin
      wd_cnt <= WD_START;
    end else if (wd_run && (wd_cnt != ALL_ONES)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign poll_at_max = (poll_cnt == ALL_ONES);
  assign gap_done    = (gap_cnt == '0);
  assign wd_expired  = (wd_cnt == ALL_ONES);

endmodule

// File: rtl/nx_indirect_access_initiator.sv
// Hardware initiator for the indirect-access register protocol: writes data
// and command registers, polls status, fetches read data, returns a response.
module nx_indirect_access_initiator
  import nx_ia_initiator_pkg::*;
#(
  parameter int unsigned CMND_ADDRESS = 0,
  parameter int unsigned STAT_ADDRESS = 0,
  parameter int unsigned DATA_ADDRESS = 0,
  parameter int N_REG_ADDR_BITS = 16,
  parameter int N_ADDR_BITS     = 10,
  parameter int N_DATA_BITS     = 32,
  parameter int N_TIMEOUT_BITS  = 8,
  parameter int POLL_GAP        = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [3:0]                 req_op,
  input  logic [N_ADDR_BITS-1:0]     req_addr,
  input  logic [N_DATA_BITS-1:0]     req_wdat,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2:0]                 rsp_code,
  output logic [N_DATA_BITS-1:0]     rsp_rdat,
  output logic                       rsp_timeout,
  output logic [N_REG_ADDR_BITS-1:0] reg_addr,
  output logic                       reg_wr_stb,
  output logic [31:0]                reg_wr_dat,
  output logic                       reg_rd_stb,
  input  logic                       reg_rd_ack,
  input  logic [31:0]                reg_rd_dat,
  output logic [3:0]                 dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // valid never depends on ready; once raised, valid and payload hold until
  // the transfer edge.

  localparam logic [N_REG_ADDR_BITS-1:0] CMND_A = N_REG_ADDR_BITS'(CMND_ADDRESS);
  localparam logic [N_REG_ADDR_BITS-1:0] STAT_A = N_REG_ADDR_BITS'(STAT_ADDRESS);
  localparam logic [N_REG_ADDR_BITS-1:0] DATA_A = N_REG_ADDR_BITS'(DATA_ADDRESS);

  ia_state_e state_q, state_d;

  logic                       alive_q;
  logic [3:0]                 op_q;
  logic [N_ADDR_BITS-1:0]     addr_q;
  logic [N_DATA_BITS-1:0]     wdat_q;
  logic [2:0]                 code_q;
  logic [N_DATA_BITS-1:0]     rdat_q;
  logic                       to_q;
  logic [N_REG_ADDR_BITS-1:0] reg_addr_q, reg_addr_d;

  logic        poll_clr, poll_inc, gap_load, wd_clr, wd_run;
  logic        poll_at_max, gap_done, wd_expired;
  logic [2:0]  ack_code;
  logic [31:0] cmd_word, wdat_ext;
  logic        accept;

  nx_ia_wait_timer #(
    .N_TIMEOUT_BITS (N_TIMEOUT_BITS),
    .POLL_GAP       (POLL_GAP)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .poll_clr    (poll_clr),
    .poll_inc    (poll_inc),
    .gap_load    (gap_load),
    .wd_clr      (wd_clr),
    .wd_run      (wd_run),
    .poll_at_max (poll_at_max),
    .gap_done    (gap_done),
    .wd_expired  (wd_expired)
  );

  assign ack_code = stat_code(reg_rd_dat);

  always_comb begin
    cmd_word = '0;
    cmd_word[CMD_OP_LSB +: 4] = op_q;
    cmd_word[N_ADDR_BITS-1:0] = addr_q;
    wdat_ext = '0;
    wdat_ext[N_DATA_BITS-1:0] = wdat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    reg_wr_stb = 1'b0;
    reg_wr_dat = '0;
    reg_rd_stb = 1'b0;
    poll_clr   = 1'b0;
    poll_inc   = 1'b0;
    gap_load   = 1'b0;
    wd_clr     = 1'b0;
    wd_run     = 1'b0;
    accept     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // alive_q keeps req_ready low until the first edge after reset.
        req_ready = alive_q;
        if (req_valid && alive_q) begin
          accept   = 1'b1;
          poll_clr = 1'b1;
          state_d  = (req_op == OP_WRITE) ? ST_WR_DATA : ST_WR_CMND;
        end
      end
      ST_WR_DATA: begin
        reg_wr_stb = 1'b1;
        reg_wr_dat = wdat_ext;
        state_d    = ST_WR_CMND;
      end
      ST_WR_CMND: begin
        reg_wr_stb = 1'b1;
        reg_wr_dat = cmd_word;
        state_d    = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        reg_rd_stb = 1'b1;
        wd_clr     = 1'b1;
        state_d    = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        wd_run = 1'b1;
        if (reg_rd_ack) begin
          if (ack_code == STAT_BUSY) begin
            if (poll_at_max) begin
              state_d = ST_RESP;
            end else begin
              poll_inc = 1'b1;
              if (POLL_GAP == 0) begin
                state_d = ST_POLL_RD;
              end else begin
                gap_load = 1'b1;
                state_d  = ST_GAP;
              end
            end
          end else if ((op_q == OP_READ) && (ack_code == STAT_OK)) begin
            state_d = ST_DATA_RD;
          end else begin
            state_d = ST_RESP;
          end
        end else if (wd_expired) begin
          state_d = ST_RESP;
        end
      end
      ST_GAP: begin
        if (gap_done) state_d = ST_POLL_RD;
      end
      ST_DATA_RD: begin
        reg_rd_stb = 1'b1;
        wd_clr     = 1'b1;
        state_d    = ST_DATA_WAIT;
      end
      ST_DATA_WAIT: begin
        wd_run = 1'b1;
        if (reg_rd_ack || wd_expired) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // reg_addr is registered and only reloaded when entering a strobe state,
  // so it holds its last value between bus accesses.
  always_comb begin
    reg_addr_d = reg_addr_q;
    case (state_d)
      ST_WR_DATA: reg_addr_d = DATA_A;
      ST_WR_CMND: reg_addr_d = CMND_A;
      ST_POLL_RD: reg_addr_d = STAT_A;
      ST_DATA_RD: reg_addr_d = DATA_A;
      default:    reg_addr_d = reg_addr_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q    <= 1'b0;
      op_q       <= '0;
      addr_q     <= '0;
      wdat_q     <= '0;
      code_q     <= '0;
      rdat_q     <= '0;
      to_q       <= 1'b0;
      reg_addr_q <= '0;
    end else begin
      alive_q    <= 1'b1;
      reg_addr_q <= reg_addr_d;
      if (accept) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        wdat_q <= req_wdat;
        code_q <= STAT_OK;
        rdat_q <= '0;
        to_q   <= 1'b0;
      end
      if (state_q == ST_POLL_WAIT) begin
        if (reg_rd_ack) begin
          if (ack_code != STAT_BUSY) begin
            code_q <= ack_code;
          end else if (poll_at_max) begin
            code_q <= STAT_BUSY;
            to_q   <= 1'b1;
          end
        end else if (wd_expired) begin
          code_q <= STAT_WDOG;
          to_q   <= 1'b1;
        end
      end
      if (state_q == ST_DATA_WAIT) begin
        if (reg_rd_ack) begin
          rdat_q <= reg_rd_dat[N_DATA_BITS-1:0];
        end else if (wd_expired) begin
          code_q <= STAT_WDOG;
          to_q   <= 1'b1;
        end
      end
    end
  end

  assign reg_addr    = reg_addr_q;
  assign rsp_code    = code_q;
  assign rsp_rdat    = rdat_q;
  assign rsp_timeout = to_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_nx_indirect_access_initiator.sv
// Directed bench for nx_indirect_access_initiator: a register-target model
// answers reads, scoreboards check bus accesses and responses.
module tb_nx_indirect_access_initiator;
  import nx_ia_initiator_pkg::*;

  localparam int NTB = 4;
  localparam int GAP = 2;
  localparam logic [15:0] CMND_A = 16'h0010;
  localparam logic [15:0] STAT_A = 16'h0014;
  localparam logic [15:0] DATA_A = 16'h0018;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [2:0]  rsp_code;
  logic [31:0] rsp_rdat;
  logic        rsp_timeout;
  logic [15:0] reg_addr;
  logic        reg_wr_stb;
  logic [31:0] reg_wr_dat;
  logic        reg_rd_stb;
  logic        reg_rd_ack;
  logic [31:0] reg_rd_dat;
  logic [3:0]  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Target model state
  logic        ack_en     = 1'b1;
  logic        late_ack   = 1'b0;
  logic        tgt_ack_q  = 1'b0;
  logic [31:0] tgt_dat_q  = '0;
  logic [2:0]  stat_q[$];
  logic [2:0]  stat_dflt  = STAT_OK;
  logic [31:0] data_word  = '0;

  // Scoreboards
  logic [49:0] exp_bus_q[$];
  logic [35:0] exp_rsp_q[$];
  int          obs_cyc_q[$];
  int          n_stat_rd = 0;
  int          n_data_rd = 0;

  nx_indirect_access_initiator #(
    .CMND_ADDRESS    (32'(CMND_A)),
    .STAT_ADDRESS    (32'(STAT_A)),
    .DATA_ADDRESS    (32'(DATA_A)),
    .N_REG_ADDR_BITS (16),
    .N_ADDR_BITS     (10),
    .N_DATA_BITS     (32),
    .N_TIMEOUT_BITS  (NTB),
    .POLL_GAP        (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdat    (req_wdat),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_code    (rsp_code),
    .rsp_rdat    (rsp_rdat),
    .rsp_timeout (rsp_timeout),
    .reg_addr    (reg_addr),
    .reg_wr_stb  (reg_wr_stb),
    .reg_wr_dat  (reg_wr_dat),
    .reg_rd_stb  (reg_rd_stb),
    .reg_rd_ack  (reg_rd_ack),
    .reg_rd_dat  (reg_rd_dat),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- register target: 1-cycle read ack ----------------
  always @(posedge clk) begin
    logic [2:0] code;
    tgt_ack_q <= 1'b0;
    if (ack_en && reg_rd_stb) begin
      tgt_ack_q <= 1'b1;
      if (reg_addr == STAT_A) begin
        code = (stat_q.size() != 0) ? stat_q.pop_front() : stat_dflt;
        tgt_dat_q <= {code, 29'h0A5A_5A5A};
      end else begin
        tgt_dat_q <= data_word;
      end
    end
  end

  assign reg_rd_ack = tgt_ack_q | late_ack;
  assign reg_rd_dat = late_ack ? 32'h0000_BEEF : tgt_dat_q;

  // ---------------- comparison helper ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [49:0] ev_wr(input logic [15:0] a, input logic [31:0] d);
    return {2'd1, a, d};
  endfunction

  function automatic logic [49:0] ev_rd(input logic [15:0] a);
    return {2'd2, a, 32'h0};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [49:0] ev;
    if (!rst && (reg_wr_stb || reg_rd_stb)) begin
      ev = {(reg_wr_stb ? 2'd1 : 2'd2), reg_addr, reg_wr_dat};
      obs_cyc_q.push_back(cyc);
      if (reg_rd_stb && reg_addr == STAT_A) n_stat_rd++;
      if (reg_rd_stb && reg_addr == DATA_A) n_data_rd++;
      n_vec++;
      assert (exp_bus_q.size() != 0) else begin
        n_miss++;
        $error("FAIL bus_unexpected: observed %h expected none", ev);
      end
      if (exp_bus_q.size() != 0) check("bus_event", 64'(ev), 64'(exp_bus_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    logic [35:0] r;
    if (!rst && rsp_valid && rsp_ready) begin
      r = {rsp_timeout, rsp_code, rsp_rdat};
      n_vec++;
      assert (exp_rsp_q.size() != 0) else begin
        n_miss++;
        $error("FAIL rsp_unexpected: observed %h expected none", r);
      end
      if (exp_rsp_q.size() != 0) check("rsp", 64'(r), 64'(exp_rsp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] op, input logic [9:0] a, input logic [31:0] wd,
                      output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdat  = wd;
    t = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_wdat  = '0;
  endtask

  task automatic wait_rsp(input int budget, output int tv);
    int k;
    k = 0;
    tv = -1;
    while (k < budget && tv < 0) begin
      @(negedge clk);
      if (rsp_valid) tv = cyc;
      k++;
    end
    check("rsp_arrived", 64'(tv >= 0), 64'd1);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    check({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  task automatic prep();
    obs_cyc_q.delete();
    n_stat_rd = 0;
    n_data_rd = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t, tv, k;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_wr_stb", 64'(reg_wr_stb), 64'd0);
    check("rst_rd_stb", 64'(reg_rd_stb), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_reg_addr", 64'(reg_addr), 64'd0);
    check("rst_wr_dat", 64'(reg_wr_dat), 64'd0);
    rst = 1'b0;
    #1;
    check("rel_req_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rel_req_ready_high", 64'(req_ready), 64'd1);

    // 1: write, status OK on first poll
    prep();
    stat_q.push_back(STAT_OK);
    exp_bus_q.push_back(ev_wr(DATA_A, 32'hA5A5_0001));
    exp_bus_q.push_back(ev_wr(CMND_A, 32'h2000_0005));
    exp_bus_q.push_back(ev_rd(STAT_A));
    exp_rsp_q.push_back({1'b0, STAT_OK, 32'h0});
    send(OP_WRITE, 10'h005, 32'hA5A5_0001, t);
    wait_rsp(50, tv);
    check("wr_latency", 64'(tv - t), 64'd5);
    check("wr_bus_count", 64'(obs_cyc_q.size()), 64'd3);
    if (obs_cyc_q.size() >= 3) begin
      check("wr_data_cyc", 64'(obs_cyc_q[0] - t), 64'd1);
      check("wr_cmnd_cyc", 64'(obs_cyc_q[1] - t), 64'd2);
      check("wr_stat_cyc", 64'(obs_cyc_q[2] - t), 64'd3);
    end
    drain("wr");

    // 2: read, BUSY twice then OK
    prep();
    stat_q.push_back(STAT_BUSY);
    stat_q.push_back(STAT_BUSY);
    stat_q.push_back(STAT_OK);
    data_word = 32'h1234_5678;
    exp_bus_q.push_back(ev_wr(CMND_A, 32'h1000_03FF));
    for (int i = 0; i < 3; i++) exp_bus_q.push_back(ev_rd(STAT_A));
    exp_bus_q.push_back(ev_rd(DATA_A));
    exp_rsp_q.push_back({1'b0, STAT_OK, 32'h1234_5678});
    send(OP_READ, 10'h3FF, 32'h0, t);
    wait_rsp(100, tv);
    check("rd_latency", 64'(tv - t), 64'(6 + 2 * (GAP + 2)));
    check("rd_stat_reads", 64'(n_stat_rd), 64'd3);
    check("rd_data_reads", 64'(n_data_rd), 64'd1);
    if (obs_cyc_q.size() >= 4) begin
      check("rd_poll_space1", 64'(obs_cyc_q[2] - obs_cyc_q[1]), 64'(GAP + 2));
      check("rd_poll_space2", 64'(obs_cyc_q[3] - obs_cyc_q[2]), 64'(GAP + 2));
    end
    drain("rd");

    // 3: status always BUSY -> poll limit
    prep();
    stat_dflt = STAT_BUSY;
    exp_bus_q.push_back(ev_wr(CMND_A, 32'h1000_0155));
    for (int i = 0; i < (1 << NTB); i++) exp_bus_q.push_back(ev_rd(STAT_A));
    exp_rsp_q.push_back({1'b1, STAT_BUSY, 32'h0});
    send(OP_READ, 10'h155, 32'h0, t);
    wait_rsp(400, tv);
    check("plim_stat_reads", 64'(n_stat_rd), 64'(1 << NTB));
    check("plim_data_reads", 64'(n_data_rd), 64'd0);
    drain("plim");
    stat_dflt = STAT_OK;

    // 4: no ack -> watchdog, then a late ack while in RESP
    prep();
    ack_en = 1'b0;
    rsp_ready = 1'b0;
    exp_bus_q.push_back(ev_wr(CMND_A, 32'h1000_00AA));
    exp_bus_q.push_back(ev_rd(STAT_A));
    exp_rsp_q.push_back({1'b1, STAT_WDOG, 32'h0});
    send(OP_READ, 10'h0AA, 32'h0, t);
    wait_rsp(100, tv);
    if (obs_cyc_q.size() >= 2) begin
      check("wdog_latency", 64'(tv - obs_cyc_q[1]), 64'(1 + (1 << NTB) - 1));
    end
    @(posedge clk);
    #1 late_ack = 1'b1;
    @(posedge clk);
    #1 late_ack = 1'b0;
    @(negedge clk);
    check("wdog_hold_valid", 64'(rsp_valid), 64'd1);
    check("wdog_code", 64'(rsp_code), 64'(STAT_WDOG));
    check("wdog_timeout", 64'(rsp_timeout), 64'd1);
    ack_en = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    drain("wdog");

    // 4b: next request proceeds normally
    prep();
    stat_q.push_back(STAT_OK);
    exp_bus_q.push_back(ev_wr(DATA_A, 32'h0000_00C3));
    exp_bus_q.push_back(ev_wr(CMND_A, 32'h2000_0001));
    exp_bus_q.push_back(ev_rd(STAT_A));
    exp_rsp_q.push_back({1'b0, STAT_OK, 32'h0});
    send(OP_WRITE, 10'h001, 32'h0000_00C3, t);
    wait_rsp(50, tv);
    check("after_wdog_latency", 64'(tv - t), 64'd5);
    drain("after_wdog");

    // 5: response back-pressure for 10 cycles
    prep();
    rsp_ready = 1'b0;
    stat_q.push_back(STAT_OK);
    data_word = 32'hCAFE_0011;
    exp_bus_q.push_back(ev_wr(CMND_A, 32'h1000_0011));
    exp_bus_q.push_back(ev_rd(STAT_A));
    exp_bus_q.push_back(ev_rd(DATA_A));
    exp_rsp_q.push_back({1'b0, STAT_OK, 32'hCAFE_0011});
    send(OP_READ, 10'h011, 32'h0, t);
    wait_rsp(50, tv);
    check("hold_latency", 64'(tv - t), 64'd6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_code", 64'(rsp_code), 64'(STAT_OK));
      check("hold_rdat", 64'(rsp_rdat), 64'hCAFE_0011);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("accept_valid_still", 64'(rsp_valid), 64'd1);
    check("accept_req_ready_low", 64'(req_ready), 64'd0);
    drain("hold");

    // 6: reset pulsed during POLL_WAIT
    prep();
    ack_en = 1'b0;
    exp_bus_q.push_back(ev_wr(CMND_A, 32'h1000_0022));
    exp_bus_q.push_back(ev_rd(STAT_A));
    send(OP_READ, 10'h022, 32'h0, t);
    k = 0;
    while (n_stat_rd == 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("abort_stat_seen", 64'(n_stat_rd), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    check("abort_rd_stb", 64'(reg_rd_stb), 64'd0);
    check("abort_wr_stb", 64'(reg_wr_stb), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    #1;
    check("abort_rel_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("abort_rel_ready_high", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("abort_no_rsp", 64'(rsp_valid), 64'd0);

    // 6b: operation after reset
    prep();
    stat_q.delete();
    stat_q.push_back(STAT_OK);
    exp_bus_q.push_back(ev_wr(DATA_A, 32'h5A5A_0F0F));
    exp_bus_q.push_back(ev_wr(CMND_A, 32'h2000_003C));
    exp_bus_q.push_back(ev_rd(STAT_A));
    exp_rsp_q.push_back({1'b0, STAT_OK, 32'h0});
    send(OP_WRITE, 10'h03C, 32'h5A5A_0F0F, t);
    wait_rsp(50, tv);
    check("post_rst_latency", 64'(tv - t), 64'd5);
    drain("post_rst");

    check("bus_leftover", 64'(exp_bus_q.size()), 64'd0);
    check("rsp_leftover", 64'(exp_rsp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
